// File: rtl/cache_ctrl_wb.sv
`default_nettype none
// ============================================================================
// Module : cache_ctrl_wb
// Direct-mapped write-back cache controller with per-line dirty bits,
// held mem_req/mem_ack handshake and a hardware flush walk.
// Rev    : 1.0  initial release
// ============================================================================
module cache_ctrl_wb #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 8,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  cpu_address,
  input  logic                   cpu_read_enable,
  input  logic                   cpu_write_enable,
  input  logic [DATA_WIDTH-1:0]  cpu_write_data,
  output logic [DATA_WIDTH-1:0]  cpu_read_data,
  output logic                   cpu_ready,
  input  logic                   flush_request,
  input  logic                   flush_invalidate,
  output logic                   flush_done,
  output logic [INDEX_WIDTH-1:0] cache_index,
  input  logic [DATA_WIDTH-1:0]  cache_read_data,
  output logic                   cache_write_enable,
  output logic [DATA_WIDTH-1:0]  cache_write_data,
  output logic                   mem_req,
  output logic                   mem_write_enable,
  output logic [ADDR_WIDTH-1:0]  mem_address,
  output logic [DATA_WIDTH-1:0]  mem_write_data,
  input  logic [DATA_WIDTH-1:0]  mem_read_data,
  input  logic                   mem_ack
);

  localparam int C_TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int C_NUM_LINES = 2 ** INDEX_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOOKUP     = 3'd1,
    ST_WRITEBACK  = 3'd2,
    ST_ALLOCATE   = 3'd3,
    ST_FLUSH_SCAN = 3'd4,
    ST_FLUSH_WB   = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [C_TAG_WIDTH-1:0]  req_tag_q, req_tag_d;
  logic [DATA_WIDTH-1:0]   req_wdata_q, req_wdata_d;
  logic                    req_write_q, req_write_d;
  logic [INDEX_WIDTH-1:0]  index_q, index_d;
  logic [INDEX_WIDTH:0]    ptr_q, ptr_d;
  logic                    flush_inv_q, flush_inv_d;
  logic [C_NUM_LINES-1:0]  valid_q, valid_d;
  logic [C_NUM_LINES-1:0]  dirty_q, dirty_d;
  logic [C_TAG_WIDTH-1:0]  tag_q [C_NUM_LINES];
  logic [C_TAG_WIDTH-1:0]  tag_d [C_NUM_LINES];

  logic                    line_valid, line_dirty, line_hit, ptr_last;
  logic [C_TAG_WIDTH-1:0]  line_tag;
  logic [INDEX_WIDTH:0]    ptr_next;
  logic [ADDR_WIDTH-1:0]   victim_addr, fill_addr;
  logic                    unused_bits;

  assign line_valid  = valid_q[index_q];
  assign line_dirty  = dirty_q[index_q];
  assign line_tag    = tag_q[index_q];
  assign line_hit    = line_valid && (line_tag == req_tag_q);
  assign ptr_next    = ptr_q + {{INDEX_WIDTH{1'b0}}, 1'b1};
  assign ptr_last    = (ptr_q[INDEX_WIDTH-1:0] == {INDEX_WIDTH{1'b1}});
  assign victim_addr = {line_tag, index_q, {OFFSET_WIDTH{1'b0}}};
  assign fill_addr   = {req_tag_q, index_q, {OFFSET_WIDTH{1'b0}}};
  assign cache_index = index_q;
  // Offset bits never select anything (one word per line); pointer MSB is wrap headroom.
  assign unused_bits = ^{cpu_address[OFFSET_WIDTH-1:0], ptr_q[INDEX_WIDTH]};

  always_comb begin
    state_d            = state_q;
    req_tag_d          = req_tag_q;
    req_wdata_d        = req_wdata_q;
    req_write_d        = req_write_q;
    index_d            = index_q;
    ptr_d              = ptr_q;
    flush_inv_d        = flush_inv_q;
    valid_d            = valid_q;
    dirty_d            = dirty_q;
    tag_d              = tag_q;
    cpu_read_data      = '0;
    cpu_ready          = 1'b0;
    flush_done         = 1'b0;
    cache_write_enable = 1'b0;
    cache_write_data   = '0;
    mem_req            = 1'b0;
    mem_write_enable   = 1'b0;
    mem_address        = '0;
    mem_write_data     = '0;

    case (state_q)
      ST_IDLE: begin
        if (cpu_read_enable || cpu_write_enable) begin
          req_tag_d   = cpu_address[ADDR_WIDTH-1 -: C_TAG_WIDTH];
          index_d     = cpu_address[OFFSET_WIDTH +: INDEX_WIDTH];
          req_wdata_d = cpu_write_data;
          req_write_d = cpu_write_enable;
          state_d     = ST_LOOKUP;
        end else if (flush_request) begin
          flush_inv_d = flush_invalidate;
          ptr_d       = '0;
          index_d     = '0;
          state_d     = ST_FLUSH_SCAN;
        end
      end

      ST_LOOKUP: begin
        if (line_hit) begin
          cpu_ready = 1'b1;
          if (req_write_q) begin
            cache_write_enable = 1'b1;
            cache_write_data   = req_wdata_q;
            dirty_d[index_q]   = 1'b1;
          end else begin
            cpu_read_data = cache_read_data;
          end
          state_d = ST_IDLE;
        end else if (line_valid && line_dirty) begin
          state_d = ST_WRITEBACK;
        end else begin
          state_d = ST_ALLOCATE;
        end
      end

      ST_WRITEBACK: begin
        mem_req          = 1'b1;
        mem_write_enable = 1'b1;
        mem_address      = victim_addr;
        mem_write_data   = cache_read_data;
        if (mem_ack) begin
          dirty_d[index_q] = 1'b0;
          state_d          = ST_ALLOCATE;
        end
      end

      ST_ALLOCATE: begin
        mem_req     = 1'b1;
        mem_address = fill_addr;
        // Return to LOOKUP so a write miss merges its store through the hit path.
        if (mem_ack) begin
          cache_write_enable = 1'b1;
          cache_write_data   = mem_read_data;
          tag_d[index_q]     = req_tag_q;
          valid_d[index_q]   = 1'b1;
          dirty_d[index_q]   = 1'b0;
          state_d            = ST_LOOKUP;
        end
      end

      ST_FLUSH_SCAN: begin
        if (line_valid && line_dirty) begin
          state_d = ST_FLUSH_WB;
        end else begin
          if (flush_inv_q) valid_d[index_q] = 1'b0;
          if (ptr_last) begin
            flush_done = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            ptr_d   = ptr_next;
            index_d = ptr_next[INDEX_WIDTH-1:0];
          end
        end
      end

      ST_FLUSH_WB: begin
        mem_req          = 1'b1;
        mem_write_enable = 1'b1;
        mem_address      = victim_addr;
        mem_write_data   = cache_read_data;
        if (mem_ack) begin
          dirty_d[index_q] = 1'b0;
          if (flush_inv_q) valid_d[index_q] = 1'b0;
          if (ptr_last) begin
            flush_done = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            ptr_d   = ptr_next;
            index_d = ptr_next[INDEX_WIDTH-1:0];
            state_d = ST_FLUSH_SCAN;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_tag_q   <= '0;
      req_wdata_q <= '0;
      req_write_q <= 1'b0;
      index_q     <= '0;
      ptr_q       <= '0;
      flush_inv_q <= 1'b0;
      valid_q     <= '0;
      dirty_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_tag_q   <= req_tag_d;
      req_wdata_q <= req_wdata_d;
      req_write_q <= req_write_d;
      index_q     <= index_d;
      ptr_q       <= ptr_d;
      flush_inv_q <= flush_inv_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
    end
  end

  // Tags are only meaningful under valid, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl_wb.sv
`default_nettype none
// ============================================================================
// Module : tb_cache_ctrl_wb
// Randomised bench for cache_ctrl_wb against a flat-memory reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_cache_ctrl_wb;
  localparam int NL = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] cpu_address, cpu_write_data, cpu_read_data;
  logic        cpu_read_enable, cpu_write_enable, cpu_ready;
  logic        flush_request, flush_invalidate, flush_done;
  logic [7:0]  cache_index;
  logic [31:0] cache_read_data, cache_write_data;
  logic        cache_write_enable;
  logic        mem_req, mem_write_enable, mem_ack;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  cache_ctrl_wb u_dut (
    .clk(clk), .rst(rst),
    .cpu_address(cpu_address), .cpu_read_enable(cpu_read_enable),
    .cpu_write_enable(cpu_write_enable), .cpu_write_data(cpu_write_data),
    .cpu_read_data(cpu_read_data), .cpu_ready(cpu_ready),
    .flush_request(flush_request), .flush_invalidate(flush_invalidate),
    .flush_done(flush_done), .cache_index(cache_index),
    .cache_read_data(cache_read_data), .cache_write_enable(cache_write_enable),
    .cache_write_data(cache_write_data), .mem_req(mem_req),
    .mem_write_enable(mem_write_enable), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .mem_ack(mem_ack)
  );

  // Small configuration used for the 16-line flush timing sweep.
  logic [15:0] s_cpu_address, s_mem_address;
  logic [31:0] s_cpu_read_data, s_cache_write_data, s_mem_write_data;
  logic        s_cpu_ready, s_flush_request, s_flush_invalidate, s_flush_done;
  logic [3:0]  s_cache_index;
  logic        s_cache_write_enable, s_mem_req, s_mem_write_enable;

  cache_ctrl_wb #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .INDEX_WIDTH(4), .OFFSET_WIDTH(2)) u_dut_small (
    .clk(clk), .rst(rst),
    .cpu_address(s_cpu_address), .cpu_read_enable(1'b0),
    .cpu_write_enable(1'b0), .cpu_write_data(32'h0),
    .cpu_read_data(s_cpu_read_data), .cpu_ready(s_cpu_ready),
    .flush_request(s_flush_request), .flush_invalidate(s_flush_invalidate),
    .flush_done(s_flush_done), .cache_index(s_cache_index),
    .cache_read_data(32'h0), .cache_write_enable(s_cache_write_enable),
    .cache_write_data(s_cache_write_data), .mem_req(s_mem_req),
    .mem_write_enable(s_mem_write_enable), .mem_address(s_mem_address),
    .mem_write_data(s_mem_write_data), .mem_read_data(32'h0),
    .mem_ack(1'b0)
  );

  // External single-word-per-line data array.
  logic [31:0] data_arr [NL];
  always @(posedge clk) if (cache_write_enable) data_arr[cache_index] <= cache_write_data;
  assign cache_read_data = data_arr[cache_index];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: architectural line values plus direct-mapped residency bookkeeping.
  logic [31:0] arch  [logic [31:0]];
  logic [31:0] mem_q [logic [31:0]];
  bit          m_valid [NL];
  bit          m_dirty [NL];
  logic [19:0] m_tag   [NL];

  function automatic logic [31:0] init_word(input logic [31:0] line);
    return (line * 32'h9E37_79B1) ^ 32'hC001_D00D;
  endfunction
  function automatic logic [31:0] arch_rd(input logic [31:0] line);
    return arch.exists(line) ? arch[line] : init_word(line);
  endfunction
  function automatic logic [31:0] mem_rd(input logic [31:0] line);
    return mem_q.exists(line) ? mem_q[line] : init_word(line);
  endfunction

  typedef struct { bit we; logic [31:0] addr; logic [31:0] data; int wt; } tx_t;
  tx_t txq[$];
  int  lat_min = 0, lat_max = 3;

  // Memory responder: acts 1 time unit after the edge, bench drives/samples at 3.
  initial begin : p_mem
    int cnt, cur_lat;
    cnt = 0; cur_lat = 0;
    mem_ack = 1'b0; mem_read_data = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_read_data = '0;
      if (rst || !mem_req) cnt = 0;
      else begin
        if (cnt == 0) cur_lat = $urandom_range(lat_max, lat_min);
        if (cnt >= cur_lat) begin
          mem_ack = 1'b1;
          if (mem_write_enable) mem_q[mem_address] = mem_write_data;
          else mem_read_data = mem_rd(mem_address);
          txq.push_back('{mem_write_enable, mem_address,
                          mem_write_enable ? mem_write_data : mem_read_data, cnt});
          cnt = 0;
        end else cnt++;
      end
    end
  end

  int done_cnt = 0, small_req_cnt = 0;
  always @(negedge clk) begin
    if (flush_done) done_cnt++;
    if (s_mem_req) small_req_cnt++;
  end

  task automatic tick();
    @(posedge clk); #3;
  endtask

  task automatic cmp_tx(input int base, input tx_t exp_q[$], inout int exp_lat);
    check_eq("mem_tx_count", txq.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < txq.size(); i++) begin
      check_eq("mem_tx_we", txq[base+i].we, exp_q[i].we);
      check_eq("mem_tx_addr", txq[base+i].addr, exp_q[i].addr);
      if (exp_q[i].we) check_eq("mem_tx_wdata", txq[base+i].data, exp_q[i].data);
      exp_lat += txq[base+i].wt + 1;
    end
  endtask

  task automatic cpu_op(input bit wr, input logic [31:0] addr, input logic [31:0] wdata, input bit also_other);
    logic [31:0] line, vline, exp_rd;
    logic [7:0]  idx;
    logic [19:0] tg;
    bit          hit;
    tx_t         exp_q[$];
    int          base, lat, exp_lat;
    line = {addr[31:4], 4'h0}; idx = addr[11:4]; tg = addr[31:12];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    exp_rd = arch_rd(line);
    if (!hit) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        vline = {m_tag[idx], idx, 4'h0};
        exp_q.push_back('{1'b1, vline, arch_rd(vline), 0});
      end
      exp_q.push_back('{1'b0, line, 32'h0, 0});
      m_valid[idx] = 1'b1; m_tag[idx] = tg; m_dirty[idx] = 1'b0;
    end
    if (wr) begin arch[line] = wdata; m_dirty[idx] = 1'b1; end
    base = txq.size();
    cpu_address = addr; cpu_write_data = wdata;
    cpu_write_enable = wr; cpu_read_enable = !wr || also_other;
    flush_request = also_other; flush_invalidate = 1'b0;
    tick();
    cpu_write_enable = 1'b0; cpu_read_enable = 1'b0; flush_request = 1'b0;
    lat = 1;
    while (!cpu_ready && lat < 200) begin tick(); lat++; end
    check_eq("cpu_ready_seen", cpu_ready, 1'b1);
    if (!wr) check_eq("cpu_read_data", cpu_read_data, exp_rd);
    exp_lat = hit ? 1 : 2;
    cmp_tx(base, exp_q, exp_lat);
    check_eq("cpu_latency", lat, exp_lat);
    tick();
  endtask

  task automatic flush_op(input bit inv, output int n_wb);
    tx_t exp_q[$];
    int  base, lat, exp_lat, d0;
    for (int i = 0; i < NL; i++) begin
      if (m_valid[i] && m_dirty[i]) begin
        exp_q.push_back('{1'b1, {m_tag[i], i[7:0], 4'h0}, arch_rd({m_tag[i], i[7:0], 4'h0}), 0});
        m_dirty[i] = 1'b0;
      end
      if (inv) m_valid[i] = 1'b0;
    end
    base = txq.size(); d0 = done_cnt;
    flush_request = 1'b1; flush_invalidate = inv;
    tick();
    flush_request = 1'b0; flush_invalidate = 1'b0;
    lat = 1;
    while (!flush_done && lat < 5000) begin tick(); lat++; end
    check_eq("flush_done_seen", flush_done, 1'b1);
    exp_lat = NL;
    cmp_tx(base, exp_q, exp_lat);
    check_eq("flush_latency", lat, exp_lat);
    tick(); tick();
    check_eq("flush_done_pulses", done_cnt - d0, 1);
    n_wb = txq.size() - base;
  endtask

  initial begin : p_watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : p_main
    int nwb, base, w, d0;
    int pool [5] = '{8'h00, 8'h10, 8'h23, 8'h7F, 8'hFF};
    logic [7:0]  ridx;
    logic [19:0] rtag;
    rst = 1'b1;
    cpu_address = '0; cpu_write_data = '0; cpu_read_enable = 1'b0; cpu_write_enable = 1'b0;
    flush_request = 1'b0; flush_invalidate = 1'b0;
    s_flush_request = 1'b0; s_flush_invalidate = 1'b0;
    repeat (3) tick();
    check_eq("rst_cpu_ready", cpu_ready, 1'b0);
    check_eq("rst_flush_done", flush_done, 1'b0);
    check_eq("rst_mem_req", {mem_req, mem_write_enable}, 2'b00);
    check_eq("rst_cache_we", cache_write_enable, 1'b0);
    check_eq("rst_cache_index", cache_index, 8'h00);
    check_eq("rst_buses", {mem_address, mem_write_data, cpu_read_data, cache_write_data}, 64'h0);
    rst = 1'b0;
    tick();

    // Read miss with a 3-cycle memory, then a rereading hit.
    mem_q[32'h0000_1230] = 32'hDEAD_BEEF; arch[32'h0000_1230] = 32'hDEAD_BEEF;
    lat_min = 3; lat_max = 3;
    cpu_op(1'b0, 32'h0000_1230, 32'h0, 1'b0);
    cpu_op(1'b0, 32'h0000_1230, 32'h0, 1'b0);
    // Write hit then conflicting read forces a writeback.
    cpu_op(1'b1, 32'h0000_1234, 32'h55AA_55AA, 1'b0);
    cpu_op(1'b0, 32'h0040_1230, 32'h0, 1'b0);
    // Write miss to a clean line, reread, then evict it.
    lat_min = 0; lat_max = 2;
    cpu_op(1'b1, 32'h0000_0100, 32'h1357_9BDF, 1'b0);
    cpu_op(1'b0, 32'h0000_0100, 32'h0, 1'b0);
    cpu_op(1'b0, 32'h0020_0100, 32'h0, 1'b0);

    // Flush with three dirty lines at the index extremes.
    cpu_op(1'b1, 32'h0000_0008, 32'hA000_0000, 1'b0);
    cpu_op(1'b1, 32'h0000_07F0, 32'hA000_007F, 1'b0);
    cpu_op(1'b1, 32'h0000_0FF0, 32'hA000_00FF, 1'b0);
    flush_op(1'b0, nwb);
    check_eq("flush_keep_wb_count", nwb, 3);
    cpu_op(1'b0, 32'h0000_0000, 32'h0, 1'b0);
    cpu_op(1'b0, 32'h0000_07F0, 32'h0, 1'b0);
    cpu_op(1'b0, 32'h0000_0FF0, 32'h0, 1'b0);
    cpu_op(1'b1, 32'h0000_0000, 32'hB000_0000, 1'b0);
    cpu_op(1'b1, 32'h0000_0FF0, 32'hB000_00FF, 1'b0);
    flush_op(1'b1, nwb);
    check_eq("flush_inv_wb_count", nwb, 2);
    cpu_op(1'b0, 32'h0000_0000, 32'h0, 1'b0);
    cpu_op(1'b0, 32'h0040_1230, 32'h0, 1'b0);

    // Read+write+flush in one cycle: a write, flush ignored.
    d0 = done_cnt;
    cpu_op(1'b1, 32'h0000_0500, 32'h0BAD_CAFE, 1'b1);
    repeat (300) tick();
    check_eq("flush_ignored", done_cnt - d0, 0);
    cpu_op(1'b0, 32'h0000_0500, 32'h0, 1'b0);

    // Randomised traffic with occasional flushes.
    for (int k = 0; k < 160; k++) begin
      lat_min = 0; lat_max = 3;
      if ($urandom_range(9, 0) == 0) flush_op(1'(($urandom_range(1, 0))), nwb);
      else begin
        w = $urandom_range(5, 0);
        ridx = (w == 5) ? 8'($urandom_range(255, 0)) : 8'(pool[w]);
        rtag = 20'($urandom_range(3, 0));
        cpu_op(1'($urandom_range(1, 0)), {rtag, ridx, 4'($urandom_range(15, 0))}, $urandom, 1'b0);
      end
    end
    flush_op(1'b1, nwb);
    flush_op(1'b0, nwb);
    check_eq("clean_flush_wb_count", nwb, 0);

    // Reset while a writeback is waiting for its acknowledge.
    cpu_op(1'b1, 32'h0000_0330, 32'hCAFE_F00D, 1'b0);
    lat_min = 1000; lat_max = 1000;
    base = txq.size();
    cpu_address = 32'h0050_0330; cpu_read_enable = 1'b1;
    tick();
    cpu_read_enable = 1'b0;
    w = 0;
    while (!(mem_req && mem_write_enable) && w < 20) begin tick(); w++; end
    check_eq("wb_pending", {mem_req, mem_write_enable}, 2'b11);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst_drops_mem_req", mem_req, 1'b0);
    check_eq("rst_no_wb", txq.size() - base, 0);
    for (int i = 0; i < NL; i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; end
    arch = mem_q;
    lat_min = 0; lat_max = 2;
    cpu_op(1'b0, 32'h0000_0330, 32'h0, 1'b0);
    cpu_op(1'b0, 32'h0000_0500, 32'h0, 1'b0);
    cpu_op(1'b0, 32'h0040_1230, 32'h0, 1'b0);

    // 16-line configuration: clean flush timing.
    for (int r = 0; r < 2; r++) begin
      s_flush_request = 1'b1; s_flush_invalidate = 1'(r);
      tick();
      s_flush_request = 1'b0; s_flush_invalidate = 1'b0;
      w = 1;
      while (!s_flush_done && w < 100) begin tick(); w++; end
      check_eq("small_flush_latency", w, 16);
      tick();
    end
    check_eq("small_no_mem_req", small_req_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
